// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches, pairs in-order responses with
// their PCs, buffers them and hands {inst, pc} to decode. Redirects flush and drop stale data.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_word [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_tag_pc    [DEPTH];
  logic [PW-1:0] r_tag_rd;
  logic [PW-1:0] r_tag_wr;

  logic          w_pop;
  logic [CW:0]   w_occupancy;
  logic          w_req_fire;
  logic          w_resp;
  logic          w_push;
  logic          w_unused;

  // Low redirect bits are architecturally ignored.
  assign w_unused = ^redirect_pc[1:0];

  assign inst_valid     = !reset && (r_count != '0) && !redirect_valid;
  assign w_pop          = inst_valid && inst_ready;
  // Credits count this cycle's pop so a full buffer streams at one word per cycle.
  assign w_occupancy    = {1'b0, r_inflight} + {1'b0, r_count} - (CW+1)'(w_pop);
  assign imem_req_valid = !reset && !redirect_valid && (w_occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_resp         = imem_resp_valid && (r_inflight != '0);
  assign w_push         = w_resp && (r_drop == '0) && !redirect_valid;

  assign inst    = r_fifo_word[r_rd_ptr];
  assign inst_pc = r_fifo_pc[r_rd_ptr];

  // Control state: PC, pointers, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_resp);
      if (w_req_fire) r_tag_wr <= r_tag_wr + PW'(1);
      if (w_resp)     r_tag_rd <= r_tag_rd + PW'(1);
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_drop     <= r_inflight - CW'(w_resp);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)     r_wr_ptr   <= r_wr_ptr + PW'(1);
        if (w_pop)      r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      end
    end
  end

  // Storage arrays need no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag_pc[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_tag_pc[r_tag_rd];
      r_fifo_word[r_wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus in-order memory with variable latency.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } ent_t;
  typedef struct packed { logic [31:0] pc; logic stale; } tag_t;

  ent_t        m_fifo[$];
  tag_t        m_infl[$];
  logic [31:0] m_pc;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due;
  int          lat_lo, lat_hi;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare after settling, advance model and memory.
  task automatic step(input logic rst, input logic iready, input logic mready,
                      input logic redir, input logic [31:0] rpc);
    logic exp_iv, exp_rv, exp_pop, resp;
    int   occ, due;
    tag_t t;
    @(negedge clk);
    cyc++;
    reset          = rst;
    inst_ready     = iready;
    imem_req_ready = mready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq_addr[0] ^ 32'hA5A5_0000;
    end
    #1;
    exp_iv  = !rst && (m_fifo.size() > 0) && !redir;
    exp_pop = exp_iv && iready;
    occ     = m_infl.size() + m_fifo.size() - (exp_pop ? 1 : 0);
    exp_rv  = !rst && !redir && (occ < int'(DEPTH));
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("inst_pc", inst_pc, m_fifo[0].pc);
      chk("inst", inst, m_fifo[0].word);
    end
    // memory environment
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      last_due = cyc;
    end else begin
      if (imem_resp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && mready) begin
        due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(due);
      end
    end
    // reference model
    if (rst) begin
      m_fifo.delete();
      m_infl.delete();
      m_pc = RPC;
    end else begin
      resp = imem_resp_valid && (m_infl.size() > 0);
      if (redir) begin
        m_fifo.delete();
        if (resp) void'(m_infl.pop_front());
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (exp_pop) void'(m_fifo.pop_front());
        if (resp) begin
          t = m_infl.pop_front();
          if (!t.stale) m_fifo.push_back({t.pc, imem_resp_data});
        end
        if (exp_rv && mready) begin
          m_infl.push_back({m_pc, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic wait_inst(input logic [31:0] exp);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (inst_valid) begin
        chk("next_inst_pc", inst_pc, exp);
        got = 1'b1;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_inst timeout got=none exp=%h", exp);
    end
  endtask

  task automatic stream(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    lat_lo = 1; lat_hi = 1; last_due = 0; m_pc = RPC;

    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);

    // reset release, then request-channel back-pressure
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_addr", imem_req_addr, 32'h0000_0100);
    chk("first_valid", 32'(imem_req_valid), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("second_addr", imem_req_addr, 32'h0000_0104);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_inst_pc", inst_pc, 32'h0000_0100);
    chk("first_inst", inst, 32'hA5A5_0100);
    chk("stall_addr0", imem_req_addr, 32'h0000_0108);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_addr1", imem_req_addr, 32'h0000_0108);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_addr2", imem_req_addr, 32'h0000_0108);
    chk("drained_inst_valid", 32'(inst_valid), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("resume_addr", imem_req_addr, 32'h0000_0108);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("resume_addr_next", imem_req_addr, 32'h0000_010C);

    // decoder stall fills the buffer
    stream(3);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("full_no_req", 32'(imem_req_valid), 32'd0);
    chk("full_inst_valid", 32'(inst_valid), 32'd1);
    stream(6);

    // long latency, two in flight, redirect
    lat_lo = 3; lat_hi = 3;
    stream(6);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
    wait_inst(32'h0000_2000);
    wait_inst(32'h0000_2004);

    // redirect colliding with a response and a pending pop
    lat_lo = 1; lat_hi = 1;
    stream(5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5000);
    chk("redir_inst_valid", 32'(inst_valid), 32'd0);
    wait_inst(32'h0000_5000);

    // unaligned redirect and address wrap
    stream(3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3003);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("aligned_redir_addr", imem_req_addr, 32'h0000_3000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
    wait_inst(32'hFFFF_FFFC);
    wait_inst(32'h0000_0000);

    // randomized traffic with redirects and mid-stream resets
    lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step(1'b0 || ($urandom_range(0, 299) == 0),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 29) == 0,
           rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
